// File: rtl/kv_csa_acc_ctrl_pkg.sv
// kv_csa_acc_ctrl_pkg: shared state encoding for the serial carry-save accumulator sequencer.
package kv_csa_acc_ctrl_pkg;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACC     = 2'd1,
        S_RESOLVE = 2'd2,
        S_DONE    = 2'd3
    } acc_state_t;
endpackage

// File: rtl/kv_csa3_2.sv
// kv_csa3_2: bitwise 3:2 carry-save compressor; cout is unshifted (weight 2^(i+1) per bit i).
module kv_csa3_2 #(
    parameter int CSA_WIDTH = 32
) (
    input  logic [CSA_WIDTH-1:0] in_a,
    input  logic [CSA_WIDTH-1:0] in_b,
    input  logic [CSA_WIDTH-1:0] in_c,
    output logic [CSA_WIDTH-1:0] sum,
    output logic [CSA_WIDTH-1:0] cout
);
    assign sum  = in_a ^ in_b ^ in_c;
    assign cout = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
endmodule

// File: rtl/kv_csa_acc_ctrl.sv
// kv_csa_acc_ctrl: serial N-operand carry-save accumulator with one final carry-propagate add.
// Define KV_CSA_ACC_OVF_EN to add the sticky unsigned-overflow output res_ovf.
module kv_csa_acc_ctrl
    import kv_csa_acc_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              core_clk,
    input  logic              core_reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [CNT_W-1:0]  start_cnt,
    input  logic              abort,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
`ifdef KV_CSA_ACC_OVF_EN
    output logic              res_ovf,
`endif
    output logic              busy
);
    acc_state_t        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_sum, r_carry, r_res, w_sum, w_cout;
    logic [CNT_W-1:0]  r_rem;
    logic              w_start, w_acc, w_resolve;

    kv_csa3_2 #(.CSA_WIDTH(DATA_W)) u_csa (
        .in_a (r_sum),
        .in_b (r_carry),
        .in_c (op_data),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_start   = r_state == S_IDLE && start_valid;
    assign w_acc     = r_state == S_ACC && op_valid && !abort;
    assign w_resolve = r_state == S_RESOLVE && !abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    w_state_nxt = start_valid ? (start_cnt == '0 ? S_RESOLVE : S_ACC) : S_IDLE;
            S_ACC:     w_state_nxt = abort ? S_IDLE : (op_valid && r_rem == CNT_W'(1)) ? S_RESOLVE : S_ACC;
            S_RESOLVE: w_state_nxt = abort ? S_IDLE : S_DONE;
            S_DONE:    w_state_nxt = (abort || res_ready) ? S_IDLE : S_DONE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // The shift drops cout's MSB, keeping the redundant pair mod 2^DATA_W.
    always_ff @(posedge core_clk) begin
        if (!core_reset_n) begin
            r_state <= S_IDLE;
            r_sum   <= '0;
            r_carry <= '0;
            r_rem   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_sum   <= '0;
                r_carry <= '0;
                r_rem   <= start_cnt;
            end
            if (w_acc) begin
                r_sum   <= w_sum;
                r_carry <= w_cout << 1;
                r_rem   <= r_rem - CNT_W'(1);
            end
            if (w_resolve) r_res <= r_sum + r_carry;
        end
    end

`ifdef KV_CSA_ACC_OVF_EN
    logic              r_ovf;
    logic [DATA_W:0]   w_cpa;
    assign w_cpa = {1'b0, r_sum} + {1'b0, r_carry};
    always_ff @(posedge core_clk) begin
        if (!core_reset_n || w_start) r_ovf <= 1'b0;
        else if (w_acc) r_ovf <= r_ovf | w_cout[DATA_W-1];
        else if (w_resolve) r_ovf <= r_ovf | w_cpa[DATA_W];
    end
    assign res_ovf = r_ovf;
`endif

    assign start_ready = r_state == S_IDLE;
    assign op_ready    = r_state == S_ACC;
    assign res_valid   = r_state == S_DONE;
    assign busy        = r_state != S_IDLE;
    assign res_data    = r_res;
endmodule

// File: tb/tb_kv_csa_acc_ctrl.sv
// tb_kv_csa_acc_ctrl: table-driven and randomized self-checking bench for kv_csa_acc_ctrl.
module tb_kv_csa_acc_ctrl;
    logic        core_clk = 0;
    logic        core_reset_n = 0;
    logic        start_valid = 0;
    logic        start_ready;
    logic [7:0]  start_cnt = 0;
    logic        abort = 0;
    logic        op_valid = 0;
    logic        op_ready;
    logic [31:0] op_data = 0;
    logic        res_valid;
    logic        res_ready = 0;
    logic [31:0] res_data;
    logic        busy;
`ifdef KV_CSA_ACC_OVF_EN
    logic        res_ovf;
`endif
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] q_ops[$];

    kv_csa_acc_ctrl #(.DATA_W(32), .CNT_W(8)) dut (
        .core_clk     (core_clk),
        .core_reset_n (core_reset_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_cnt    (start_cnt),
        .abort        (abort),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_data      (op_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
`ifdef KV_CSA_ACC_OVF_EN
        .res_ovf      (res_ovf),
`endif
        .busy         (busy)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        int          cnt;
        logic [31:0] op[4];
        logic [31:0] res;
        logic        ovf;
        int          gap;
        int          bp;
    } vec_t;
    vec_t tbl[5];

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain wide-integer sum of the job's operands.
    function automatic logic [32:0] model_sum();
        longint unsigned s = 0;
        foreach (q_ops[i]) s += 64'(q_ops[i]);
        return {s >= 64'h1_0000_0000, s[31:0]};
    endfunction

    task automatic run_job(input int cnt, input int gap, input int bp, input logic [31:0] exp_res, input logic exp_ovf);
        logic [31:0] held;
        chk("start_ready_idle", {31'b0, start_ready}, 1);
        start_valid = 1;
        start_cnt = cnt[7:0];
        tick();
        start_valid = 0;
        chk("busy_after_start", {31'b0, busy}, 1);
        for (int k = 0; k < cnt; k++) begin
            repeat ((k % 2 == 1) ? gap : 0) begin
                op_valid = 0;
                op_data = $urandom;
                chk("op_ready_bubble", {31'b0, op_ready}, 1);
                tick();
            end
            op_valid = 1;
            op_data = q_ops[k];
            chk("op_ready_acc", {31'b0, op_ready}, 1);
            tick();
        end
        op_valid = 0;
        op_data = $urandom;
        chk("res_valid_t1", {31'b0, res_valid}, 0);
        chk("op_ready_resolve", {31'b0, op_ready}, 0);
        tick();
        chk("res_valid_t2", {31'b0, res_valid}, 1);
        chk("res_data", res_data, exp_res);
`ifdef KV_CSA_ACC_OVF_EN
        chk("res_ovf", {31'b0, res_ovf}, {31'b0, exp_ovf});
`else
        if (exp_ovf === 1'bx) chk("ovf_model", 0, 1);
`endif
        held = exp_res;
        repeat (bp) begin
            tick();
            chk("res_valid_hold", {31'b0, res_valid}, 1);
            chk("res_data_hold", res_data, held);
            chk("start_ready_done", {31'b0, start_ready}, 0);
            chk("op_ready_done", {31'b0, op_ready}, 0);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        chk("res_valid_after_hs", {31'b0, res_valid}, 0);
        chk("busy_after_hs", {31'b0, busy}, 0);
    endtask

    initial begin
        logic [32:0] m;
        tick();
        tick();
        chk("rst_start_ready", {31'b0, start_ready}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_res_valid", {31'b0, res_valid}, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_op_ready", {31'b0, op_ready}, 0);
        core_reset_n = 1;
        tick();

        tbl[0] = '{3, '{32'd1, 32'd2, 32'd3, 32'd0}, 32'd6, 1'b0, 0, 0};
        tbl[1] = '{0, '{32'd9, 32'd9, 32'd9, 32'd9}, 32'd0, 1'b0, 0, 0};
        tbl[2] = '{2, '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd0}, 32'd0, 1'b1, 0, 0};
        tbl[3] = '{2, '{32'd5, 32'hFFFFFFFF, 32'd0, 32'd0}, 32'd4, 1'b1, 0, 1};
        tbl[4] = '{4, '{32'd10, 32'd20, 32'd30, 32'd40}, 32'd100, 1'b0, 2, 5};
        for (int i = 0; i < 5; i++) begin
            q_ops = {};
            for (int j = 0; j < tbl[i].cnt; j++) q_ops.push_back(tbl[i].op[j]);
            run_job(tbl[i].cnt, tbl[i].gap, tbl[i].bp, tbl[i].res, tbl[i].ovf);
        end

        // abort in ACC with an operand offered in the same cycle
        start_valid = 1; start_cnt = 5; tick(); start_valid = 0;
        op_valid = 1; op_data = 11; tick();
        op_data = 22; tick();
        op_data = 33; abort = 1; tick();
        abort = 0; op_valid = 0;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_start_ready", {31'b0, start_ready}, 1);
        chk("abort_res_valid", {31'b0, res_valid}, 0);
        abort = 1; tick(); abort = 0;
        chk("abort_idle_ignored", {31'b0, start_ready}, 1);
        q_ops = {32'd7};
        run_job(1, 0, 0, 32'd7, 1'b0);

        // abort in DONE wins over res_ready
        start_valid = 1; start_cnt = 1; tick(); start_valid = 0;
        op_valid = 1; op_data = 9; tick(); op_valid = 0;
        tick();
        chk("done_before_abort", {31'b0, res_valid}, 1);
        abort = 1; res_ready = 1; tick(); abort = 0; res_ready = 0;
        chk("abort_done_res_valid", {31'b0, res_valid}, 0);
        chk("abort_done_busy", {31'b0, busy}, 0);

        // reset mid-ACC
        start_valid = 1; start_cnt = 3; tick(); start_valid = 0;
        op_valid = 1; op_data = 100; tick(); op_valid = 0;
        core_reset_n = 0; tick(); core_reset_n = 1;
        chk("rmid_busy", {31'b0, busy}, 0);
        chk("rmid_res_data", res_data, 0);
        chk("rmid_op_ready", {31'b0, op_ready}, 0);
        chk("rmid_res_valid", {31'b0, res_valid}, 0);
        q_ops = {32'd3, 32'd4};
        run_job(2, 0, 0, 32'd7, 1'b0);

        // reset wins over a simultaneous start
        start_valid = 1; start_cnt = 2; core_reset_n = 0; tick();
        start_valid = 0; core_reset_n = 1;
        chk("rst_vs_start_busy", {31'b0, busy}, 0);

        // randomized jobs against the wide-integer model, plus a max-length job
        for (int r = 0; r < 25; r++) begin
            int cnt;
            cnt = (r == 24) ? 255 : int'($urandom_range(0, 12));
            q_ops = {};
            for (int j = 0; j < cnt; j++)
                q_ops.push_back(($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 3) : $urandom);
            m = model_sum();
            run_job(cnt, $urandom_range(0, 2), $urandom_range(0, 3), m[31:0], m[32]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
